seq_div: RTL and testbench
==========================

# seq_div

Multi-cycle unsigned restoring divider for the CPU's ALU. It is the inverse of the ripple adder datapath: each cycle it runs one trial subtraction through a ripple chain of one-bit full subtractors and develops one quotient bit, MSB first. It sits beside the adder/ALU and is driven by the control unit through a start/done handshake.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width. Must be at least 2.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request a divide. Sampled only while idle.
- `dividend`, input, WIDTH: numerator, captured on the accepted start.
- `divisor`, input, WIDTH: denominator, captured on the accepted start.
- `busy`, output, 1: high from the cycle after an accepted start until done.
- `done`, output, 1: one-cycle pulse; results are valid in that cycle.
- `quotient`, output, WIDTH: result, held until the next accepted start.
- `remainder`, output, WIDTH: result, held until the next accepted start.
- `div_by_zero`, output, 1: set with done when the captured divisor is 0; held like the results.

## Operation
- FSM states:
  - IDLE: default state.
  - RUN: `busy`=1. Iteration counter loads WIDTH and decrements once per cycle.
  - DONE: `done`=1, `busy`=0. Lasts exactly one cycle, then returns to IDLE.
- Transitions:
  - IDLE→RUN: `start`=1 and divisor≠0. Captures operands, clears the partial remainder.
  - IDLE→DONE: `start`=1 and divisor=0. Divide-by-zero path.
  - RUN→DONE: counter reaches 0.
- RUN iteration:
  - P = {P[WIDTH-1:0], dividend_reg MSB}, WIDTH+1 bits; then shift dividend_reg left by 1.
  - D = P − {0,divisor} through a WIDTH+1-bit ripple of one-bit subtractors.
  - No final borrow: P←D, quotient bit 1. Borrow: P unchanged (restore), quotient bit 0.
  - Quotient bits shift in at the LSB.
- Divide-by-zero: `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1.
- `start` while busy or in DONE is ignored, with no effect on the operation in flight.
- Outputs update only on entry to DONE. They are stable from the `done` cycle until the next accepted start.

## Timing
- Reset state: IDLE. `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter and internal registers 0.
- `rst` mid-operation aborts: the next cycle is IDLE with all outputs at their reset values. `rst` overrides `start`.
- Latency for divisor≠0: start sampled at edge k; `busy` high after edges k+1..k+WIDTH; `done` high for the cycle following edge k+WIDTH+1.
- Latency for divisor=0: `done` high for the cycle after edge k+1.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE. The earliest restart is 1 cycle after `done`.
- Result width is always exact: quotient ≤ dividend and remainder < divisor, so there is no overflow in unsigned mode.

## Configuration
- `SEQ_DIV_SIGNED_EN` defined: operands are two's complement.
  - Magnitudes are taken on capture, adding one IDLE→RUN cycle with no latency change to the iteration count.
  - Quotient is negated if the operand signs differ (truncation toward zero). Remainder takes the dividend's sign. The negation is applied when entering DONE.
  - Most-negative / −1: quotient = most-negative (wraps), remainder 0.
  - Divide-by-zero: as unsigned (all ones, remainder = dividend).
- Not defined: purely unsigned. No sign logic is present.

## Structure
- Shared package `alu_pkg`: FSM state enum (IDLE/RUN/DONE), counter width `$clog2(WIDTH+1)`.
- Sub-module `bSubtract`: one-bit full subtractor with inputs A, B, b_in and outputs diff, b_out, built from xor/and/or/not gate instances. `seq_div` instantiates WIDTH+1 of them in a generate ripple.

## Test plan
- 100/7 (WIDTH=8) → `quotient`=14, `remainder`=2, `div_by_zero`=0; `done` exactly 9 edges after the start edge; `busy` high for 8 cycles.
- 5/0 → `done` 1 cycle after start; `quotient`=0xFF, `remainder`=0x05, `div_by_zero`=1.
- 255/1 → 255 r 0. 3/200 → 0 r 3. Results held through 20 idle cycles.
- `start` pulsed with 9/2 at cycle 3 of a running 100/7 → 100/7 result unaffected, no second `done`. Restart accepted 1 cycle after `done`.
- `rst` asserted at cycle 4 of 200/3 → next cycle all outputs 0 and IDLE. A fresh 200/3 then gives 66 r 2.
- `SEQ_DIV_SIGNED_EN`: −7/2 → `quotient`=0xFD, `remainder`=0xFF. −128/−1 → 0x80 r 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states and the iteration counter width helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to hold the value w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bSubtract.sv
// One-bit full subtractor built from primitive gates: diff = A - B - b_in.
module bSubtract (
  input  logic A,
  input  logic B,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  logic a_xor_b;
  logic not_a;
  logic not_axb;
  logic gen;
  logic prop;

  xor x0 (a_xor_b, A, B);
  xor x1 (diff, a_xor_b, b_in);
  not n0 (not_a, A);
  not n1 (not_axb, a_xor_b);
  and a0 (gen, not_a, B);
  and a1 (prop, not_axb, b_in);
  or  o0 (b_out, gen, prop);

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider, one quotient bit per cycle, MSB first.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_div
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             pending;
  logic             accept;
  logic             load_done;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] p_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   div_ext;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] bor;
  logic             q_bit;
  logic [WIDTH-1:0] p_iter;
  logic [WIDTH-1:0] quo_iter;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;
  logic             unused_bits;

  assign accept = start && (state == IDLE) && !pending;

`ifdef SEQ_DIV_SIGNED_EN
  logic dvd_neg_q;
  logic dsr_neg_q;

  assign dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign dsr_mag = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_neg_q <= 1'b0;
      dsr_neg_q <= 1'b0;
    end else if (accept) begin
      dvd_neg_q <= dividend[WIDTH-1];
      dsr_neg_q <= divisor[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
`endif

  // Trial subtraction P - {0,divisor} through the ripple chain.
  assign p_shift = {p_q, dvd_q[WIDTH-1]};
  assign div_ext = {1'b0, dsr_q};
  assign bor[0]  = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    bSubtract u_sub (
      .A     (p_shift[i]),
      .B     (div_ext[i]),
      .b_in  (bor[i]),
      .diff  (diff[i]),
      .b_out (bor[i+1])
    );
  end

  // A surviving top bit is impossible once P is restored below the divisor.
  assign q_bit       = ~bor[WIDTH+1];
  assign p_iter      = q_bit ? diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
  assign quo_iter    = {quo_q[WIDTH-2:0], q_bit};
  assign unused_bits = ^{diff[WIDTH], quo_q[WIDTH-1]};

  // Final results presented on entry to DONE.
  always_comb begin
    res_q = quo_iter;
    res_r = p_iter;
    if (dsr_q == '0) begin
      res_q = '1;
      res_r = dvd_q;
    end
`ifdef SEQ_DIV_SIGNED_EN
    if ((dsr_q != '0) && (dvd_neg_q ^ dsr_neg_q)) res_q = ~res_q + WIDTH'(1);
    if (dvd_neg_q) res_r = ~res_r + WIDTH'(1);
`endif
  end

  always_comb begin
    state_next = state;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          if (dsr_q != '0) begin
            state_next = RUN;
          end else begin
            state_next = DONE;
            load_done  = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_next = DONE;
          load_done  = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pending     <= 1'b0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      quo_q       <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      if (accept) begin
        pending <= 1'b1;
        dvd_q   <= dvd_mag;
        dsr_q   <= dsr_mag;
      end else if (pending) begin
        pending <= 1'b0;
        p_q     <= '0;
        quo_q   <= '0;
        cnt_q   <= CW'(WIDTH);
      end
      if (state == RUN) begin
        p_q   <= p_iter;
        quo_q <= quo_iter;
        dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
        cnt_q <= cnt_q - CW'(1);
      end
      if (load_done) begin
        quotient    <= res_q;
        remainder   <= res_r;
        div_by_zero <= (dsr_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=8, unsigned build) against an arithmetic model.
module tb_seq_div;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = W'(a / b);
      r = W'(a % b);
      z = 1'b0;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where done is first seen.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (start) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) break;
    end
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         ez;
    int           edges, bcyc;
    model(a, b, eq, er, ez);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(edges, bcyc);
    check_eq({tag, "_lat"}, edges, (b == 0) ? 1 : W + 1);
    check_eq({tag, "_busy"}, bcyc, (b == 0) ? 0 : W);
    check_eq({tag, "_q"}, quotient, eq);
    check_eq({tag, "_r"}, remainder, er);
    check_eq({tag, "_dbz"}, div_by_zero, ez);
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int edges, bcyc, extra;
    logic [W-1:0] a, b;

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_q", quotient, 0);
    check_eq("rst_r", remainder, 0);
    check_eq("rst_dbz", div_by_zero, 0);

    run_div("d100_7", 8'd100, 8'd7);
    run_div("d5_0", 8'd5, 8'd0);
    run_div("d255_1", 8'd255, 8'd1);
    run_div("d3_200", 8'd3, 8'd200);

    // Results must hold while idle.
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check_eq("hold_q", quotient, 0);
    check_eq("hold_r", remainder, 3);
    check_eq("hold_done", extra, 0);

    // A start while busy must not disturb the divide in flight.
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("ign_busy", busy, 1);
    start = 1'b1;
    dividend = 8'd9;
    divisor = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 8'd100;
    divisor = 8'd7;
    wait_done(edges, bcyc);
    check_eq("ign_lat", edges + 4, W + 1);
    check_eq("ign_q", quotient, 14);
    check_eq("ign_r", remainder, 2);
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check_eq("ign_second_done", extra, 0);

    // Restart in the cycle right after done.
    run_div("b2b_a", 8'd77, 8'd5);
    run_div("b2b_b", 8'd64, 8'd8);

    // Reset mid-operation aborts to reset values.
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_busy_pre", busy, 1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_q", quotient, 0);
    check_eq("abort_r", remainder, 0);
    check_eq("abort_dbz", div_by_zero, 0);
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    check_eq("abort_idle", extra, 0);
    run_div("d200_3", 8'd200, 8'd3);

    // Randomized operands, including occasional zero divisors.
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_div($sformatf("rnd%0d", i), a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
